// File: rtl/pin_scan_uart.sv
// rtl/pin_scan_uart.sv - board pin scanner that announces each pin index over UART 8N1
// Optional macro PIN_SCAN_HOLD_EN adds hold_i, which freezes the dwell countdown.
`timescale 1ns/1ps
module pin_scan_uart #(
  parameter int CLK_FREQ      = 25000000,
  parameter int BAUDRATE      = 9600,
  parameter int NUM_PINS      = 8,
  parameter int DWELL_CYCLES  = 25000000,
  parameter int TOGGLE_CYCLES = 1250000
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef PIN_SCAN_HOLD_EN
  input  logic                hold_i,
`endif
  input  logic                enable_i,
  output logic [NUM_PINS-1:0] pins_o,
  output logic                tx_o,
  output logic                led_o,
  output logic                busy_o,
  output logic [6:0]          idx_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUDRATE;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int DWELL_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int TOG_W    = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(TOGGLE_CYCLES - 1);
  localparam logic [6:0]         IDX_LAST   = 7'(NUM_PINS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DWELL} state_t;

  state_t               r_state, w_next_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [3:0]           r_bit;
  logic [1:0]           r_byte;
  logic [DWELL_W-1:0]   r_dwell;
  logic [TOG_W-1:0]     r_tog;
  logic [NUM_PINS-1:0]  r_pins;
  logic                 r_tx, r_led, r_busy;
  logic [6:0]           r_idx;

  logic                 w_hold, w_send_done, w_dwell_done, w_start, w_tog_hit;
  logic [6:0]           w_tens, w_units;
  logic [7:0]           w_char;
  logic [NUM_PINS-1:0]  w_pin_mask;

`ifdef PIN_SCAN_HOLD_EN
  assign w_hold = hold_i;
`else
  assign w_hold = 1'b0;
`endif

  assign w_send_done  = (r_baud == BAUD_LAST) && (r_bit == 4'd9) && (r_byte == 2'd3);
  assign w_dwell_done = (r_dwell == DWELL_LAST) && !w_hold;
  assign w_tog_hit    = (r_tog == TOG_LAST);
  assign w_tens       = r_idx / 7'd10;
  assign w_units      = r_idx % 7'd10;
  assign w_pin_mask   = NUM_PINS'(1) << r_idx;

  always_comb begin
    w_char = 8'h0A;
    case (r_byte)
      2'd0:    w_char = 8'h30 | {1'b0, w_tens};
      2'd1:    w_char = 8'h30 | {1'b0, w_units};
      2'd2:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE:  if (enable_i) begin
                 w_next_state = S_SEND;
                 w_start      = 1'b1;
               end
      S_SEND:  if (w_send_done) w_next_state = S_DWELL;
      S_DWELL: if (w_dwell_done) begin
                 w_next_state = enable_i ? S_SEND : S_IDLE;
                 w_start      = enable_i;
               end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_dwell <= '0;
      r_tog   <= '0;
      r_pins  <= '0;
      r_tx    <= 1'b1;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      if (r_state != S_IDLE) begin
        if (w_tog_hit) begin
          r_tog  <= '0;
          r_pins <= r_pins ^ w_pin_mask;
        end else begin
          r_tog <= r_tog + 1'b1;
        end
      end
      if (r_state == S_SEND) begin
        if (r_baud == BAUD_LAST) begin
          r_baud <= '0;
          if (r_bit == 4'd9) begin
            // Next byte's start bit follows the stop bit directly; after byte 3 the line idles high.
            r_bit   <= '0;
            r_byte  <= r_byte + 1'b1;
            r_tx    <= w_send_done;
            r_dwell <= '0;
          end else begin
            r_bit <= r_bit + 1'b1;
            r_tx  <= (r_bit == 4'd8) ? 1'b1 : w_char[r_bit[2:0]];
          end
        end else begin
          r_baud <= r_baud + 1'b1;
        end
      end
      if ((r_state == S_DWELL) && !w_hold) r_dwell <= r_dwell + 1'b1;
      if ((r_state == S_DWELL) && w_dwell_done) begin
        r_idx  <= (r_idx == IDX_LAST) ? 7'd0 : r_idx + 1'b1;
        r_led  <= ~r_led;
        r_pins <= '0;
      end
      if (w_start) begin
        r_tx   <= 1'b0;
        r_baud <= '0;
        r_bit  <= '0;
        r_byte <= '0;
        r_tog  <= '0;
        r_pins <= '0;
      end
    end
  end

  assign pins_o = r_pins;
  assign tx_o   = r_tx;
  assign led_o  = r_led;
  assign busy_o = r_busy;
  assign idx_o  = r_idx;

endmodule

// File: tb/tb_pin_scan_uart.sv
// tb/tb_pin_scan_uart.sv - self-checking bench for pin_scan_uart
// Build with PIN_SCAN_HOLD_EN defined to also exercise hold_i.
`timescale 1ns/1ps
module tb_pin_scan_uart;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
`ifdef PIN_SCAN_HOLD_EN
  logic          hold = 1'b0;
`endif
  logic [NP-1:0] pins_o;
  logic          tx_o, led_o, busy_o;
  logic [6:0]    idx_o;

  int   checks = 0;
  int   errors = 0;
  int   exp_idx = 0;
  logic exp_led = 1'b0;

  pin_scan_uart #(
    .CLK_FREQ(1000), .BAUDRATE(100), .NUM_PINS(NP), .DWELL_CYCLES(200), .TOGGLE_CYCLES(5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
`ifdef PIN_SCAN_HOLD_EN
    .hold_i(hold),
`endif
    .enable_i(enable),
    .pins_o(pins_o),
    .tx_o(tx_o),
    .led_o(led_o),
    .busy_o(busy_o),
    .idx_o(idx_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] msg_char(input int idx, input int n);
    case (n)
      0:       return 8'(48 + idx / 10);
      1:       return 8'(48 + idx % 10);
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Line level t cycles into a step: 4 frames of 10 bits x 10 cycles, then idle high.
  function automatic logic exp_tx(input int idx, input int t);
    int n, b;
    logic [7:0] ch;
    if (t >= 400) return 1'b1;
    n  = t / 100;
    b  = (t % 100) / 10;
    ch = msg_char(idx, n);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  task automatic check_idle(input string tag, input int idx, input logic led);
    chk({tag, "_tx"},   32'(tx_o),   32'(1));
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    chk({tag, "_pins"}, 32'(pins_o), 32'(0));
    chk({tag, "_idx"},  32'(idx_o),  32'(idx));
    chk({tag, "_led"},  32'(led_o),  32'(led));
  endtask

  task automatic check_step(input int idx, input logic led, input int drop_at, input int rst_at,
                            input int hold_start, input int hold_len);
    int len, bad_tx, bad_pins, bad_busy, bad_idx, b;
    logic [7:0]    rx;
    logic [NP-1:0] exp_pins;
    len = 600 + hold_len;
    bad_tx = 0; bad_pins = 0; bad_busy = 0; bad_idx = 0; rx = '0;
    for (int t = 0; t < len; t++) begin
      tick;
      if (t == 0) chk($sformatf("led_step_idx%0d", idx), 32'(led_o), 32'(led));
      exp_pins = (((t / 5) % 2) != 0) ? NP'(1 << idx) : '0;
      if (tx_o !== exp_tx(idx, t)) bad_tx++;
      if (pins_o !== exp_pins) bad_pins++;
      if (busy_o !== 1'b1) bad_busy++;
      if (idx_o !== 7'(idx)) bad_idx++;
      if (t < 400 && (t % 10) == 5) begin
        b = (t % 100) / 10;
        if (b >= 1 && b <= 8) rx[b-1] = tx_o;
        if (b == 9) begin
          chk($sformatf("stop_bit_idx%0d_byte%0d", idx, t / 100), 32'(tx_o), 32'(1));
          chk($sformatf("rx_byte_idx%0d_byte%0d", idx, t / 100), 32'(rx), 32'(msg_char(idx, t / 100)));
        end
      end
      if (t == drop_at) enable = 1'b0;
`ifdef PIN_SCAN_HOLD_EN
      if (hold_len > 0 && t == hold_start - 1) hold = 1'b1;
      if (hold_len > 0 && t == hold_start + hold_len - 1) hold = 1'b0;
`endif
      if (t == rst_at) begin
        rst = 1'b1;
        enable = 1'b0;
        break;
      end
    end
    if (hold_start < 0) bad_tx++;
    chk($sformatf("tx_cycles_idx%0d", idx),   32'(bad_tx),   32'(0));
    chk($sformatf("pins_cycles_idx%0d", idx), 32'(bad_pins), 32'(0));
    chk($sformatf("busy_cycles_idx%0d", idx), 32'(bad_busy), 32'(0));
    chk($sformatf("idx_cycles_idx%0d", idx),  32'(bad_idx),  32'(0));
  endtask

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    check_idle("reset", 0, 1'b0);
    repeat ($urandom_range(1, 20)) tick;
    check_idle("idle_no_enable", 0, 1'b0);

    // Continuous scan across all pins including the wrap back to 0.
    enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      check_step(exp_idx, exp_led, -1, -1, 0, 0);
      exp_idx = (exp_idx + 1) % NP;
      exp_led = ~exp_led;
    end

    // Enable dropped mid-message: the step completes, then the scanner idles.
    check_step(exp_idx, exp_led, $urandom_range(1, 399), -1, 0, 0);
    exp_idx = (exp_idx + 1) % NP;
    exp_led = ~exp_led;
    tick;
    check_idle("after_drop", exp_idx, exp_led);
    repeat ($urandom_range(5, 30)) tick;
    check_idle("idle_hold_off", exp_idx, exp_led);

    // Reset inside a data bit of byte 1, then a clean restart.
    enable = 1'b1;
    check_step(exp_idx, exp_led, -1, $urandom_range(111, 188), 0, 0);
    tick;
    check_idle("mid_byte_reset", 0, 1'b0);
    rst = 1'b0;
    exp_idx = 0;
    exp_led = 1'b0;
    enable = 1'b1;
    check_step(exp_idx, exp_led, $urandom_range(1, 399), -1, 0, 0);
    exp_idx = (exp_idx + 1) % NP;
    exp_led = ~exp_led;
    tick;
    check_idle("restart_done", exp_idx, exp_led);

`ifdef PIN_SCAN_HOLD_EN
    enable = 1'b1;
    check_step(exp_idx, exp_led, $urandom_range(1, 399), -1, $urandom_range(401, 450), 300);
    exp_idx = (exp_idx + 1) % NP;
    exp_led = ~exp_led;
    tick;
    check_idle("after_hold", exp_idx, exp_led);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pin_scan_uart.md
Name: pin_scan_uart

Overview:
Parametrised board pin scanner for pin-mapping unknown boards.
- Walks an index across NUM_PINS output pins. Only the selected pin toggles at a fixed rate; all other pins are held low.
- At the start of each scan step, announces the pin index over a UART 8N1 transmitter as two ASCII decimal digits followed by CR LF.
- Replaces per-design derived clocks: all timing comes from clock enables on the single clk_i domain.
- Sits at top level between board pins and the FTDI TX line.

Parameters:
CLK_FREQ, 25000000, input clock frequency in Hz
BAUDRATE, 9600, UART bit rate; BAUD_DIV = CLK_FREQ / BAUDRATE (integer division, must be >= 2)
NUM_PINS, 8, number of scanned pins, 1..100
DWELL_CYCLES, 25000000, clk_i cycles spent in DWELL per pin, >= 1
TOGGLE_CYCLES, 1250000, clk_i cycles between toggles of the active pin, >= 1

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, synchronous, active-high
enable_i  input  1  run scan; sampled in IDLE and at end of each DWELL
pins_o  output  NUM_PINS  scanned pins; only pins_o[idx_o] may be high
tx_o  output  1  UART TX, idle high
led_o  output  1  toggles on every index advance
busy_o  output  1  high in SEND and DWELL
idx_o  output  7  current pin index, 0..NUM_PINS-1

Behaviour:
- Reset (rst_i high at a clk_i edge), effective that edge, in any state including mid-byte:
  - state=IDLE, tx_o=1, pins_o=0, led_o=0, busy_o=0, idx_o=0.
  - All counters cleared.
- All outputs are registered.
- States and transitions:
  - IDLE: if enable_i=1 at edge k -> SEND. busy_o=1 and tx_o=0 (start bit of byte 0) from edge k+1.
  - SEND: transmit 4 bytes back-to-back, with no idle gap between a stop bit and the next start bit:
    - byte 0: tens digit = 0x30 + idx/10
    - byte 1: units digit = 0x30 + idx%10
    - byte 2: 0x0D
    - byte 3: 0x0A
    - Each bit is held exactly BAUD_DIV cycles; frame is start(0), 8 data LSB first, stop(1).
    - SEND lasts 40*BAUD_DIV cycles, then -> DWELL.
  - DWELL: counts DWELL_CYCLES, then advances:
    - idx_o increments, wrapping NUM_PINS-1 -> 0.
    - led_o toggles.
    - Next state is SEND if enable_i=1, else IDLE (busy_o=0).
- Active pin:
  - pins_o[idx_o] toggles every TOGGLE_CYCLES, during both SEND and DWELL.
  - On entry to SEND the toggle counter clears and the active pin starts low.
  - On index advance the old pin drops low in the same cycle.
  - In IDLE, pins_o=0.
- enable_i deasserted during SEND or DWELL: the current step completes (message plus dwell), then IDLE. No truncated UART frames.
- NUM_PINS=1: idx_o stays 0. led_o still toggles each step.
- Counter widths are derived with $clog2 from the parameters; no overflow for the stated ranges.

Optional Feature:
PIN_SCAN_HOLD_EN
- Defined: adds input port hold_i (1 bit).
  - While hold_i=1 in DWELL, the dwell counter freezes, so the scan stays on the current pin.
  - The active pin keeps toggling while held.
  - hold_i has no effect in IDLE or SEND.
- Undefined: the port is absent and the block behaves as if hold_i=0.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1000, BAUDRATE=100 (BAUD_DIV=10), NUM_PINS=3, DWELL_CYCLES=200, TOGGLE_CYCLES=5.
1. Reset, then enable_i=1 from edge k -> tx_o=0 at k+1. The UART decoder receives 0x30,0x30,0x0D,0x0A with each bit 10 cycles wide. busy_o=1 for 600 cycles, then idx_o=1 and led_o=1.
2. Continuous enable for 3 steps -> messages "00","01","02", then the 4th message is "00" (wrap). pins_o walks 001,010,100,001 and is never multi-hot.
3. Active pin timing -> during step 0, pins_o[0] is low for 5 cycles, high for 5 cycles, repeating. pins_o[2:1]=0 throughout.
4. Drop enable_i in mid-SEND of step 1 -> the full "01" CR LF message and 200-cycle dwell complete, then IDLE with busy_o=0, pins_o=0, idx_o=2, tx_o=1.
5. Assert rst_i mid data bit of byte 1 -> next edge: tx_o=1, idx_o=0, led_o=0, pins_o=0. A restart with enable_i sends "00" again.
6. With PIN_SCAN_HOLD_EN defined, hold_i=1 for 300 cycles during DWELL -> idx_o advances 300 cycles later than without hold, and pins_o[idx] keeps toggling throughout.
